// File: rtl/accel_playback.sv
// Replays a ROM sequence of X/Y/Z samples, one per SAMPLE_DIV tick: 1-cycle ROM read, then a registered sample held under a valid/ready handshake.
// A held sample stalls the address and a tick missed in READ/HOLD sets sticky overrun; ACCEL_PLAYBACK_LOOP_EN makes playback wrap to address 0 instead of stopping.
module accel_playback #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int SAMPLE_DIV    = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  output logic                     rom_ce,
  output logic                     rom_read_en,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]    rom_data_x,
  input  logic [DATA_WIDTH-1:0]    rom_data_y,
  input  logic [DATA_WIDTH-1:0]    rom_data_z,
  output logic [DATA_WIDTH-1:0]    sample_x,
  output logic [DATA_WIDTH-1:0]    sample_y,
  output logic [DATA_WIDTH-1:0]    sample_z,
  output logic [ADDRESS_WIDTH-1:0] sample_addr,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]         DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [DATA_WIDTH-1:0]    sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic [ADDRESS_WIDTH-1:0] saddr_q, saddr_d;
  logic                     valid_q, valid_d;
  logic                     ce_q, ce_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     overrun_q, overrun_d;
  logic                     tick;

  assign tick = (state_q != IDLE) && (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    div_d     = div_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    sz_d      = sz_q;
    saddr_d   = saddr_q;
    valid_d   = valid_q;
    ce_d      = 1'b0;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = '0;
          div_d     = '0;
          overrun_d = 1'b0;
          state_d   = READ;
          ce_d      = 1'b1;
        end
      end
      READ: begin
        sx_d    = rom_data_x;
        sy_d    = rom_data_y;
        sz_d    = rom_data_z;
        saddr_d = addr_q;
        valid_d = 1'b1;
        state_d = HOLD;
        if (tick) overrun_d = 1'b1;
      end
      HOLD: begin
        if (tick) overrun_d = 1'b1;
        if (sample_ready) begin
          valid_d = 1'b0;
          if (addr_q == ADDR_LAST) begin
            done_d  = 1'b1;
`ifdef ACCEL_PLAYBACK_LOOP_EN
            addr_d  = '0;
            state_d = WAIT;
`else
            state_d = IDLE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (tick) begin
          state_d = READ;
          ce_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort beats any handshake or tick in the same cycle; the address is left untouched.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      addr_d  = addr_q;
      valid_d = 1'b0;
      ce_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      div_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      sz_q      <= '0;
      saddr_q   <= '0;
      valid_q   <= 1'b0;
      ce_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      div_q     <= div_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      sz_q      <= sz_d;
      saddr_q   <= saddr_d;
      valid_q   <= valid_d;
      ce_q      <= ce_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign rom_ce       = ce_q;
  assign rom_read_en  = ce_q;
  assign rom_address  = addr_q;
  assign sample_x     = sx_q;
  assign sample_y     = sy_q;
  assign sample_z     = sz_q;
  assign sample_addr  = saddr_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_accel_playback.sv
// Directed bench for accel_playback with SAMPLE_DIV=4 and a 16-entry ROM (x=1000+a, y=2000+a, z=3000+a).
module tb_accel_playback;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, sample_ready;
  logic          rom_ce, rom_read_en, sample_valid, busy, done, overrun;
  logic [AW-1:0] rom_address, sample_addr;
  logic [DW-1:0] rom_data_x, rom_data_y, rom_data_z;
  logic [DW-1:0] sample_x, sample_y, sample_z;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign rom_data_x = 16'h1000 + {12'h000, rom_address};
  assign rom_data_y = 16'h2000 + {12'h000, rom_address};
  assign rom_data_z = 16'h3000 + {12'h000, rom_address};

  accel_playback #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .SAMPLE_DIV   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .rom_ce      (rom_ce),
    .rom_read_en (rom_read_en),
    .rom_address (rom_address),
    .rom_data_x  (rom_data_x),
    .rom_data_y  (rom_data_y),
    .rom_data_z  (rom_data_z),
    .sample_x    (sample_x),
    .sample_y    (sample_y),
    .sample_z    (sample_z),
    .sample_addr (sample_addr),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    sample_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rom_ce", 32'(rom_ce), 32'd0);
    check("rst_sample_x", 32'(sample_x), 32'd0);
    check("rst_sample_addr", 32'(sample_addr), 32'd0);

    // Free-running playback with ready tied high
    sample_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("c1_rom_ce", 32'(rom_ce), 32'd1);
    check("c1_rom_read_en", 32'(rom_read_en), 32'd1);
    check("c1_busy", 32'(busy), 32'd1);
    check("c1_valid", 32'(sample_valid), 32'd0);
    check("c1_rom_address", 32'(rom_address), 32'd0);
    step();
    check("c2_valid", 32'(sample_valid), 32'd1);
    check("c2_sample_x", 32'(sample_x), 32'h1000);
    check("c2_sample_y", 32'(sample_y), 32'h2000);
    check("c2_sample_z", 32'(sample_z), 32'h3000);
    check("c2_sample_addr", 32'(sample_addr), 32'd0);
    check("c2_rom_ce", 32'(rom_ce), 32'd0);
    step();
    check("c3_valid", 32'(sample_valid), 32'd0);
    check("c3_rom_address", 32'(rom_address), 32'd1);
    step();
    step();
    step();
    check("s1_valid", 32'(sample_valid), 32'd1);
    check("s1_addr", 32'(sample_addr), 32'd1);
    check("s1_x", 32'(sample_x), 32'h1001);
    for (int k = 2; k < 16; k++) begin
      repeat (4) step();
      check("seq_valid", 32'(sample_valid), 32'd1);
      check("seq_addr", 32'(sample_addr), 32'(k));
      check("seq_x", 32'(sample_x), 32'h1000 + 32'(k));
    end
    step();
    check("end_done", 32'(done), 32'd1);
    check("end_rom_ce", 32'(rom_ce), 32'd0);
    check("end_overrun", 32'(overrun), 32'd0);
`ifdef ACCEL_PLAYBACK_LOOP_EN
    check("end_busy_loop", 32'(busy), 32'd1);
    repeat (3) step();
    check("wrap_valid", 32'(sample_valid), 32'd1);
    check("wrap_addr", 32'(sample_addr), 32'd0);
    check("wrap_x", 32'(sample_x), 32'h1000);
    check("wrap_busy", 32'(busy), 32'd1);
`else
    check("end_busy", 32'(busy), 32'd0);
    check("end_valid", 32'(sample_valid), 32'd0);
    step();
    check("done_pulse_end", 32'(done), 32'd0);
`endif
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop1_busy", 32'(busy), 32'd0);
    check("stop1_valid", 32'(sample_valid), 32'd0);

    // Held sample: stable data, overrun, no advance
    sample_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(sample_valid), 32'd1);
      check("hold_x", 32'(sample_x), 32'h1000);
      check("hold_addr", 32'(rom_address), 32'd0);
      step();
    end
    check("hold_overrun", 32'(overrun), 32'd1);
    check("hold_x_end", 32'(sample_x), 32'h1000);
    sample_ready = 1'b1;
    step();
    check("hs_valid", 32'(sample_valid), 32'd0);
    check("hs_rom_address", 32'(rom_address), 32'd1);
    repeat (5) step();
    check("next_valid", 32'(sample_valid), 32'd1);
    check("next_addr", 32'(sample_addr), 32'd1);
    check("next_x", 32'(sample_x), 32'h1001);

    // Stop in WAIT
    step();
    check("wait_valid", 32'(sample_valid), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stopw_busy", 32'(busy), 32'd0);
    check("stopw_valid", 32'(sample_valid), 32'd0);
    check("stopw_overrun_sticky", 32'(overrun), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_rom_address", 32'(rom_address), 32'd0);
    check("restart_overrun", 32'(overrun), 32'd0);
    check("restart_rom_ce", 32'(rom_ce), 32'd1);
    sample_ready = 1'b0;
    step();
    check("restart_valid", 32'(sample_valid), 32'd1);
    check("restart_addr", 32'(sample_addr), 32'd0);

    // Stop together with start in HOLD: stop wins
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("stoph_busy", 32'(busy), 32'd0);
    check("stoph_valid", 32'(sample_valid), 32'd0);
    check("stoph_rom_ce", 32'(rom_ce), 32'd0);
    step();
    check("stoph_stays_idle", 32'(busy), 32'd0);

    // Reset during HOLD with overrun set, start asserted alongside
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (3) step();
    check("prerst_valid", 32'(sample_valid), 32'd1);
    check("prerst_overrun", 32'(overrun), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    step();
    check("mrst_valid", 32'(sample_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);
    check("mrst_rom_ce", 32'(rom_ce), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_sample_x", 32'(sample_x), 32'd0);
    check("mrst_sample_addr", 32'(sample_addr), 32'd0);
    check("mrst_rom_address", 32'(rom_address), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_rom_ce", 32'(rom_ce), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
